// File: rtl/univ_reg_n.sv
// rtl/univ_reg_n.sv - parametrised multi-mode register (hold/load/shift/rotate/inc/dec)
//
// Purpose:
//   N-bit general-purpose storage, shift and count element. All state
//   changes on the rising edge of CLK. Priority at each edge is
//   CLR > (EN==0 hold) > MODE.
//
// Ports:
//   CLK   in   1      rising-edge clock
//   CLR   in   1      synchronous active-high clear (Q<=RST_VAL, SO<=0, CO<=0)
//   EN    in   1      operation enable, 0 holds all state
//   MODE  in   3      000 hold, 001 load, 010 shl, 011 shr,
//                     100 rotl, 101 rotr, 110 inc, 111 dec
//   D     in   WIDTH  parallel load data
//   SIL   in   1      serial input entering the LSB on shl
//   SIR   in   1      serial input entering the MSB on shr
//   Q     out  WIDTH  registered contents
//   QN    out  WIDTH  ~Q, combinational
//   SO    out  1      bit shifted/rotated out by the last shift or rotate
//   CO    out  1      carry/borrow of the last inc or dec
module univ_reg_n #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIL,
  input  logic             SIR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             SO,
  output logic             CO
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  logic [WIDTH-1:0] r_q;
  logic             r_so;
  logic             r_co;

  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_rotl;
  logic [WIDTH-1:0] w_rotr;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;
  logic             w_carry;
  logic             w_borrow;

  // A one-bit register has no Q[W-2:0] slice; shifting degenerates to
  // loading the serial input and rotating to a no-op.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_shl  = SIL;
      assign w_shr  = SIR;
      assign w_rotl = r_q;
      assign w_rotr = r_q;
    end else begin : g_wn
      assign w_shl  = {r_q[WIDTH-2:0], SIL};
      assign w_shr  = {SIR, r_q[WIDTH-1:1]};
      assign w_rotl = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      assign w_rotr = {r_q[0], r_q[WIDTH-1:1]};
    end
  endgenerate

  assign w_inc    = r_q + WIDTH'(1);
  assign w_dec    = r_q - WIDTH'(1);
  assign w_carry  = &r_q;   // all-ones wraps to zero on inc
  assign w_borrow = ~|r_q;  // zero wraps to all-ones on dec

  // The hold path is decided by EN alone so unknown MODE/D while
  // disabled never reaches the state.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_q  <= RST_VAL;
      r_so <= 1'b0;
      r_co <= 1'b0;
    end else if (EN) begin
      case (MODE)
        MODE_HOLD: begin
          r_q  <= r_q;
          r_so <= r_so;
          r_co <= r_co;
        end
        MODE_LOAD: begin
          r_q  <= D;
          r_so <= 1'b0;
          r_co <= 1'b0;
        end
        MODE_SHL: begin
          r_q  <= w_shl;
          r_so <= r_q[WIDTH-1];
          r_co <= 1'b0;
        end
        MODE_SHR: begin
          r_q  <= w_shr;
          r_so <= r_q[0];
          r_co <= 1'b0;
        end
        MODE_ROTL: begin
          r_q  <= w_rotl;
          r_so <= r_q[WIDTH-1];
          r_co <= 1'b0;
        end
        MODE_ROTR: begin
          r_q  <= w_rotr;
          r_so <= r_q[0];
          r_co <= 1'b0;
        end
        MODE_INC: begin
          r_q  <= w_inc;
          r_so <= 1'b0;
          r_co <= w_carry;
        end
        MODE_DEC: begin
          r_q  <= w_dec;
          r_so <= 1'b0;
          r_co <= w_borrow;
        end
        default: begin
          r_q  <= r_q;
          r_so <= r_so;
          r_co <= r_co;
        end
      endcase
    end
  end

  assign Q  = r_q;
  assign QN = ~r_q;
  assign SO = r_so;
  assign CO = r_co;

endmodule
